// File: rtl/riscv_pkg.sv
// Shared definitions for the fetch/decode slice: RV32I base opcodes, fetch FSM
// states and immediate formats, plus the opcode classification helpers.
package riscv_pkg;

    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        HOLD  = 2'd1,
        DRAIN = 2'd2
    } fetch_state_t;

    typedef enum logic [2:0] {
        IMM_NONE = 3'd0,
        IMM_I    = 3'd1,
        IMM_S    = 3'd2,
        IMM_B    = 3'd3,
        IMM_U    = 3'd4,
        IMM_J    = 3'd5
    } imm_fmt_t;

    function automatic imm_fmt_t imm_format(input logic [6:0] opc);
        imm_fmt_t fmt;
        fmt = IMM_NONE;
        case (opc)
            OPC_OP_IMM, OPC_LOAD, OPC_JALR, OPC_SYSTEM: fmt = IMM_I;
            OPC_STORE:                                  fmt = IMM_S;
            OPC_BRANCH:                                 fmt = IMM_B;
            OPC_LUI, OPC_AUIPC:                         fmt = IMM_U;
            OPC_JAL:                                    fmt = IMM_J;
            default:                                    fmt = IMM_NONE;
        endcase
        return fmt;
    endfunction

    function automatic logic is_base_opcode(input logic [6:0] opc);
        logic ok;
        ok = 1'b0;
        case (opc)
            OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_BRANCH, OPC_LOAD,
            OPC_STORE, OPC_OP_IMM, OPC_OP, OPC_MISC_MEM, OPC_SYSTEM: ok = 1'b1;
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/riscv_fetch_decode_if.sv
// Bundle of the instruction-memory, redirect and decode-output signals of the
// fetch/decode block; master is the fetch/decode side, slave the environment.
interface riscv_fetch_decode_if #(
    parameter int unsigned XLEN = 32
);
    // Handshakes: a transfer happens on a rising edge where valid (imem_req /
    // dec_valid) and ready (imem_ack / dec_ready) are both high; the valid side
    // keeps address/payload stable until then, and ready may be high any time.
    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic            imem_ack;
    logic [31:0]     imem_rdata;

    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;

    logic            dec_valid;
    logic            dec_ready;
    logic [XLEN-1:0] pc;
    logic [6:0]      opcode;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [XLEN-1:0] imm;
    logic            illegal;

    modport master (
        output imem_req, imem_addr,
        input  imem_ack, imem_rdata,
        input  redirect_valid, redirect_pc,
        output dec_valid,
        input  dec_ready,
        output pc, opcode, rs1, rs2, rd, funct3, funct7, imm, illegal
    );

    modport slave (
        input  imem_req, imem_addr,
        output imem_ack, imem_rdata,
        output redirect_valid, redirect_pc,
        input  dec_valid,
        output dec_ready,
        input  pc, opcode, rs1, rs2, rd, funct3, funct7, imm, illegal
    );

endinterface

// File: rtl/riscv_fetch_fifo.sv
// Fetch buffer: small power-of-two FIFO with synchronous flush. A push into a
// full buffer is dropped even when a pop happens in the same cycle.
module riscv_fetch_fifo #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned DEPTH = 4,
    localparam int unsigned AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      count
);

    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      cnt;
    logic             do_push;
    logic             do_pop;

    assign full     = (cnt == FULL_CNT);
    assign empty    = (cnt == '0);
    assign count    = cnt;
    assign do_push  = push & ~full;
    assign do_pop   = pop & ~empty;
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + (AW + 1)'(1);
                2'b01:   cnt <= cnt - (AW + 1)'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    // Storage needs no reset; occupancy is tracked by cnt alone.
    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/riscv_fetch_decode.sv
// RV32I instruction fetch with a small prefetch buffer and combinational decode
// of the buffer head; redirects flush the buffer and drain any stale transfer.
module riscv_fetch_decode
    import riscv_pkg::*;
#(
    parameter int unsigned     XLEN      = 32,
    parameter int unsigned     BUF_DEPTH = 4,
    parameter logic [XLEN-1:0] RESET_PC  = '0
) (
    input  logic                 clk,
    input  logic                 reset,
    riscv_fetch_decode_if.master bus,
    output fetch_state_t         state_dbg
);

    localparam int unsigned     CW       = $clog2(BUF_DEPTH) + 1;
    localparam int unsigned     EW       = XLEN + 32;
    localparam logic [CW-1:0]   LAST_CNT = CW'(BUF_DEPTH - 1);

    fetch_state_t    state, state_nxt;
    logic [XLEN-1:0] fetch_pc, fetch_pc_nxt;
    logic [XLEN-1:0] drain_addr, drain_addr_nxt;
    logic [XLEN-1:0] redirect_aligned;

    logic            push, pop;
    logic            fifo_full, fifo_empty;
    logic [CW-1:0]   fifo_count;
    logic [EW-1:0]   head;
    logic [31:0]     instr;
    logic [XLEN-1:0] head_pc;

    assign redirect_aligned = {bus.redirect_pc[XLEN-1:2], 2'b00};

    // Reset gates the request combinationally so it drops the instant reset rises.
    assign bus.imem_req  = ~reset & (state != HOLD);
    assign bus.imem_addr = (state == DRAIN) ? drain_addr : fetch_pc;

    assign push = (state == FETCH) & bus.imem_req & bus.imem_ack
                & ~bus.redirect_valid & ~fifo_full;
    assign pop  = bus.dec_valid & bus.dec_ready & ~bus.redirect_valid;

    riscv_fetch_fifo #(
        .WIDTH (EW),
        .DEPTH (BUF_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .flush     (bus.redirect_valid),
        .push      (push),
        .push_data ({fetch_pc, bus.imem_rdata}),
        .pop       (pop),
        .pop_data  (head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= FETCH;
            fetch_pc   <= RESET_PC;
            drain_addr <= RESET_PC;
        end else begin
            state      <= state_nxt;
            fetch_pc   <= fetch_pc_nxt;
            drain_addr <= drain_addr_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        fetch_pc_nxt   = fetch_pc;
        drain_addr_nxt = drain_addr;
        case (state)
            FETCH: begin
                if (bus.redirect_valid) begin
                    fetch_pc_nxt = redirect_aligned;
                    // An unacknowledged request must finish at its old address.
                    if (!bus.imem_ack) begin
                        state_nxt      = DRAIN;
                        drain_addr_nxt = fetch_pc;
                    end
                end else if (push) begin
                    fetch_pc_nxt = fetch_pc + XLEN'(4);
                    // Stop requesting before the buffer fills so no ack is lost.
                    if (!pop && (fifo_count == LAST_CNT)) state_nxt = HOLD;
                end
            end
            HOLD: begin
                if (bus.redirect_valid) begin
                    fetch_pc_nxt = redirect_aligned;
                    state_nxt    = FETCH;
                end else if (pop) begin
                    state_nxt = FETCH;
                end
            end
            DRAIN: begin
                if (bus.redirect_valid) fetch_pc_nxt = redirect_aligned;
                if (bus.imem_ack)       state_nxt    = FETCH;
            end
            default: state_nxt = FETCH;
        endcase
    end

    assign state_dbg     = state;
    assign bus.dec_valid = ~fifo_empty;
    assign instr         = head[31:0];
    assign head_pc       = head[EW-1:32];

    logic signed [31:0] imm32;

    always_comb begin
        imm32 = '0;
        case (imm_format(instr[6:0]))
            IMM_I: imm32 = {{20{instr[31]}}, instr[31:20]};
            IMM_S: imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            IMM_B: imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25],
                            instr[11:8], 1'b0};
            IMM_U: imm32 = {instr[31:12], 12'b0};
            IMM_J: imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20],
                            instr[30:21], 1'b0};
            default: imm32 = '0;
        endcase
    end

    // Decode outputs read as zero whenever there is no valid head entry.
    always_comb begin
        bus.pc      = '0;
        bus.opcode  = '0;
        bus.rd      = '0;
        bus.funct3  = '0;
        bus.rs1     = '0;
        bus.rs2     = '0;
        bus.funct7  = '0;
        bus.imm     = '0;
        bus.illegal = 1'b0;
        if (bus.dec_valid) begin
            bus.pc      = head_pc;
            bus.opcode  = instr[6:0];
            bus.rd      = instr[11:7];
            bus.funct3  = instr[14:12];
            bus.rs1     = instr[19:15];
            bus.rs2     = instr[24:20];
            bus.funct7  = instr[31:25];
            bus.imm     = XLEN'(imm32);
            bus.illegal = (instr[1:0] != 2'b11) | ~is_base_opcode(instr[6:0]);
        end
    end

endmodule

// File: tb/tb_riscv_fetch_decode.sv
// Directed bench for riscv_fetch_decode: one task per scenario, hand-computed
// expected addresses and decode fields.
module tb_riscv_fetch_decode;
    import riscv_pkg::*;

    logic         clk;
    logic         reset;
    fetch_state_t state_dbg;
    int           n_cmp = 0;
    int           n_bad = 0;
    logic [31:0]  exp_q[$];

    riscv_fetch_decode_if #(.XLEN(32)) bus ();

    riscv_fetch_decode #(
        .XLEN      (32),
        .BUF_DEPTH (4),
        .RESET_PC  (32'h0)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .state_dbg (state_dbg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset              = 1'b1;
        bus.imem_ack       = 1'b0;
        bus.imem_rdata     = 32'h0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 32'h0;
        bus.dec_ready      = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        reset              = 1'b1;
        bus.imem_ack       = 1'b1;
        bus.imem_rdata     = 32'h00500093;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 32'h0;
        bus.dec_ready      = 1'b1;
        tick();
        tick();
        n_cmp++; if (bus.imem_req !== 1'b0) begin n_bad++; $display("FAIL reset_req got %b want 0", bus.imem_req); end
        n_cmp++; if (bus.dec_valid !== 1'b0) begin n_bad++; $display("FAIL reset_dec_valid got %b want 0", bus.dec_valid); end
        n_cmp++; if (bus.imm !== 32'h0 || bus.pc !== 32'h0 || bus.opcode !== 7'h0) begin n_bad++; $display("FAIL reset_decode got pc %h imm %h opc %h want 0", bus.pc, bus.imm, bus.opcode); end
        n_cmp++; if (state_dbg !== FETCH) begin n_bad++; $display("FAIL reset_state got %0d want %0d", state_dbg, FETCH); end
    endtask

    task automatic test_stream();
        do_reset();
        bus.imem_ack   = 1'b1;
        bus.imem_rdata = 32'h00500093;
        bus.dec_ready  = 1'b1;
        #1;
        n_cmp++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h0) begin n_bad++; $display("FAIL stream_first_req got req %b addr %h want 1 0", bus.imem_req, bus.imem_addr); end
        tick();
        n_cmp++; if (bus.imem_addr !== 32'h4) begin n_bad++; $display("FAIL stream_addr1 got %h want 4", bus.imem_addr); end
        n_cmp++; if (bus.dec_valid !== 1'b1 || bus.pc !== 32'h0) begin n_bad++; $display("FAIL stream_head0 got valid %b pc %h want 1 0", bus.dec_valid, bus.pc); end
        n_cmp++; if (bus.opcode !== 7'b0010011 || bus.rd !== 5'd1 || bus.rs1 !== 5'd0) begin n_bad++; $display("FAIL stream_fields got opc %h rd %0d rs1 %0d want 13 1 0", bus.opcode, bus.rd, bus.rs1); end
        n_cmp++; if (bus.imm !== 32'd5 || bus.illegal !== 1'b0 || bus.funct3 !== 3'd0 || bus.rs2 !== 5'd5) begin n_bad++; $display("FAIL stream_imm got imm %h ill %b f3 %0d rs2 %0d want 5 0 0 5", bus.imm, bus.illegal, bus.funct3, bus.rs2); end
        tick();
        n_cmp++; if (bus.imem_addr !== 32'h8 || bus.pc !== 32'h4 || bus.dec_valid !== 1'b1) begin n_bad++; $display("FAIL stream_b2b got addr %h pc %h valid %b want 8 4 1", bus.imem_addr, bus.pc, bus.dec_valid); end
        tick();
        n_cmp++; if (bus.imem_addr !== 32'hC || bus.pc !== 32'h8) begin n_bad++; $display("FAIL stream_b2b2 got addr %h pc %h want c 8", bus.imem_addr, bus.pc); end
        bus.imem_ack = 1'b0;
    endtask

    task automatic test_hold();
        int xfers;
        xfers = 0;
        do_reset();
        exp_q = '{32'h0, 32'h4, 32'h8, 32'hC};
        bus.imem_ack   = 1'b1;
        bus.imem_rdata = 32'h00000013;
        #1;
        for (int i = 0; i < 8; i++) begin
            if (bus.imem_req && bus.imem_ack) begin
                xfers++;
                n_cmp++;
                if (exp_q.size() == 0) begin n_bad++; $display("FAIL hold_extra_xfer got addr %h want none", bus.imem_addr); end
                else begin
                    logic [31:0] e;
                    e = exp_q.pop_front();
                    if (bus.imem_addr !== e) begin n_bad++; $display("FAIL hold_addr got %h want %h", bus.imem_addr, e); end
                end
            end
            tick();
        end
        n_cmp++; if (xfers != 4) begin n_bad++; $display("FAIL hold_count got %0d want 4", xfers); end
        n_cmp++; if (bus.imem_req !== 1'b0 || state_dbg !== HOLD) begin n_bad++; $display("FAIL hold_state got req %b st %0d want 0 %0d", bus.imem_req, state_dbg, HOLD); end
        bus.dec_ready = 1'b1;
        tick();
        bus.dec_ready = 1'b0;
        #1;
        n_cmp++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h10) begin n_bad++; $display("FAIL hold_refetch got req %b addr %h want 1 10", bus.imem_req, bus.imem_addr); end
        n_cmp++; if (bus.pc !== 32'h4) begin n_bad++; $display("FAIL hold_pop_head got pc %h want 4", bus.pc); end
        tick();
        n_cmp++; if (bus.imem_req !== 1'b0 || state_dbg !== HOLD) begin n_bad++; $display("FAIL hold_refill got req %b st %0d want 0 %0d", bus.imem_req, state_dbg, HOLD); end
        bus.imem_ack = 1'b0;
    endtask

    task automatic test_drain();
        do_reset();
        bus.dec_ready = 1'b1;
        tick();
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h103;
        tick();
        bus.redirect_valid = 1'b0;
        #1;
        n_cmp++; if (state_dbg !== DRAIN || bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h0) begin n_bad++; $display("FAIL drain_enter got st %0d req %b addr %h want %0d 1 0", state_dbg, bus.imem_req, bus.imem_addr, DRAIN); end
        tick();
        bus.imem_ack   = 1'b1;
        bus.imem_rdata = 32'h00100093;
        #1;
        n_cmp++; if (bus.imem_addr !== 32'h0) begin n_bad++; $display("FAIL drain_addr_stable got %h want 0", bus.imem_addr); end
        tick();
        bus.imem_rdata = 32'h00200113;
        #1;
        n_cmp++; if (bus.dec_valid !== 1'b0 || state_dbg !== FETCH || bus.imem_addr !== 32'h100) begin n_bad++; $display("FAIL drain_exit got valid %b st %0d addr %h want 0 %0d 100", bus.dec_valid, state_dbg, bus.imem_addr, FETCH); end
        tick();
        n_cmp++; if (bus.dec_valid !== 1'b1 || bus.pc !== 32'h100 || bus.rd !== 5'd2 || bus.imm !== 32'd2) begin n_bad++; $display("FAIL drain_first got valid %b pc %h rd %0d imm %h want 1 100 2 2", bus.dec_valid, bus.pc, bus.rd, bus.imm); end
        bus.imem_ack = 1'b0;
    endtask

    task automatic test_imm();
        logic [31:0] tbl [3];
        tbl = '{32'hFE000EE3, 32'h800000EF, 32'h00000010};
        do_reset();
        bus.imem_ack = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.imem_rdata = tbl[i];
            tick();
        end
        bus.imem_ack = 1'b0;
        #1;
        n_cmp++; if (bus.opcode !== 7'h63 || bus.imm !== 32'hFFFFFFFC || bus.illegal !== 1'b0) begin n_bad++; $display("FAIL imm_beq got opc %h imm %h ill %b want 63 fffffffc 0", bus.opcode, bus.imm, bus.illegal); end
        bus.dec_ready = 1'b1;
        tick();
        bus.dec_ready = 1'b0;
        #1;
        n_cmp++; if (bus.opcode !== 7'h6F || bus.imm !== 32'hFFF00000 || bus.rd !== 5'd1 || bus.illegal !== 1'b0) begin n_bad++; $display("FAIL imm_jal got opc %h imm %h rd %0d ill %b want 6f fff00000 1 0", bus.opcode, bus.imm, bus.rd, bus.illegal); end
        bus.dec_ready = 1'b1;
        tick();
        bus.dec_ready = 1'b0;
        #1;
        n_cmp++; if (bus.dec_valid !== 1'b1 || bus.illegal !== 1'b1 || bus.imm !== 32'h0 || bus.pc !== 32'h8) begin n_bad++; $display("FAIL imm_illegal got valid %b ill %b imm %h pc %h want 1 1 0 8", bus.dec_valid, bus.illegal, bus.imm, bus.pc); end
        bus.dec_ready = 1'b1;
        tick();
        bus.dec_ready = 1'b0;
        #1;
        n_cmp++; if (bus.dec_valid !== 1'b0 || bus.pc !== 32'h0 || bus.opcode !== 7'h0 || bus.illegal !== 1'b0) begin n_bad++; $display("FAIL imm_empty_zero got valid %b pc %h opc %h ill %b want 0 0 0 0", bus.dec_valid, bus.pc, bus.opcode, bus.illegal); end
    endtask

    task automatic test_wrap();
        do_reset();
        bus.dec_ready      = 1'b1;
        bus.imem_ack       = 1'b1;
        bus.imem_rdata     = 32'h00500093;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'hFFFFFFFC;
        tick();
        bus.redirect_valid = 1'b0;
        #1;
        n_cmp++; if (bus.dec_valid !== 1'b0 || state_dbg !== FETCH || bus.imem_addr !== 32'hFFFFFFFC) begin n_bad++; $display("FAIL wrap_redirect_ack got valid %b st %0d addr %h want 0 %0d fffffffc", bus.dec_valid, state_dbg, bus.imem_addr, FETCH); end
        tick();
        n_cmp++; if (bus.imem_addr !== 32'h0 || bus.dec_valid !== 1'b1 || bus.pc !== 32'hFFFFFFFC) begin n_bad++; $display("FAIL wrap_addr got addr %h valid %b pc %h want 0 1 fffffffc", bus.imem_addr, bus.dec_valid, bus.pc); end
        tick();
        n_cmp++; if (bus.imem_addr !== 32'h4 || bus.pc !== 32'h0) begin n_bad++; $display("FAIL wrap_next got addr %h pc %h want 4 0", bus.imem_addr, bus.pc); end
        bus.imem_ack = 1'b0;
    endtask

    task automatic test_reset_mid();
        do_reset();
        bus.imem_ack   = 1'b1;
        bus.imem_rdata = 32'h00500093;
        tick();
        bus.imem_ack = 1'b0;
        #1;
        n_cmp++; if (bus.imem_req !== 1'b1 || bus.dec_valid !== 1'b1 || bus.imem_addr !== 32'h4) begin n_bad++; $display("FAIL rmid_pre got req %b valid %b addr %h want 1 1 4", bus.imem_req, bus.dec_valid, bus.imem_addr); end
        reset = 1'b1;
        #1;
        n_cmp++; if (bus.imem_req !== 1'b0 || bus.dec_valid !== 1'b0 || bus.opcode !== 7'h0 || state_dbg !== FETCH) begin n_bad++; $display("FAIL rmid_now got req %b valid %b opc %h st %0d want 0 0 0 %0d", bus.imem_req, bus.dec_valid, bus.opcode, state_dbg, FETCH); end
        tick();
        reset = 1'b0;
        #1;
        n_cmp++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h0 || state_dbg !== FETCH || bus.dec_valid !== 1'b0) begin n_bad++; $display("FAIL rmid_restart got req %b addr %h st %0d valid %b want 1 0 %0d 0", bus.imem_req, bus.imem_addr, state_dbg, bus.dec_valid, FETCH); end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_hold();
        test_drain();
        test_imm();
        test_wrap();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
